// File: rtl/sysarray_skew_feeder.sv
// sysarray_skew_feeder
// Upstream feeder for an N x N systolic matrix-multiply array. It takes one
// column of A and one row of B per handshake beat and drives them onto the
// west (a_edge) and north (b_edge) edges of the array. Lane i is delayed by
// i+1 cycles, so matching partial products meet in the correct PE. The
// feeder also sequences a whole job: clear accumulators, feed len beats,
// drain with zeros until every product has been accumulated, then pulse done.
//
// Ports:
//   clock       system clock, all logic on the rising edge
//   reset       synchronous, active-high; aborts any job in flight
//   start       job request, honoured only in IDLE and only when len != 0
//   len         job length in beats (K dimension), latched at start
//   in_valid    a_vec/b_vec carry a valid beat
//   in_ready    feeder accepts a beat this cycle
//   a_vec       A column, lane i = bits [i*W +: W]
//   b_vec       B row, same lane packing
//   a_edge      skewed west-edge data, lane i to array row i
//   b_edge      skewed north-edge data, lane i to array column i
//   lane_valid  bit i high when lane i of both edges carries a real beat
//   clear_acc   one-cycle pulse zeroing the PE accumulators
//   busy        high whenever the feeder is not IDLE
//   done        one-cycle pulse, all products of the job are accumulated
module sysarray_skew_feeder #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int LW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [LW-1:0]   len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  a_vec,
    input  logic [N*W-1:0]  b_vec,
    output logic [N*W-1:0]  a_edge,
    output logic [N*W-1:0]  b_edge,
    output logic [N-1:0]    lane_valid,
    output logic            clear_acc,
    output logic            busy,
    output logic            done
);

    // The last beat reaches lane N-1 after N-1 further cycles of feeder skew,
    // and the array needs 2N-1 more cycles for it to reach the far corner PE.
    localparam int DRAIN_CYC = 3 * N - 2;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   drn_q, drn_d;
    logic            accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        drn_d     = drn_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        clear_acc = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear_acc = 1'b1;
                state_d   = S_FEED;
            end
            S_FEED: begin
                // Once the len-th beat is in, the feeder spends one more cycle
                // in FEED with in_ready low; the counter stops at len, so
                // len = 2^LW-1 never wraps.
                in_ready = (cnt_q != len_q);
                accept   = in_ready && in_valid;
                if (accept) begin
                    cnt_d = cnt_q + LW'(1);
                end
                if (cnt_q == len_q) begin
                    drn_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drn_q == DW'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skew chains: lane i holds i+1 stages. Stage 0 loads the accepted beat
    // or zero, so gaps between beats always carry zero data, never stale.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] a_sr_q [i+1];
        logic [W-1:0] b_sr_q [i+1];
        logic         v_sr_q [i+1];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int j = 0; j <= i; j++) begin
                    a_sr_q[j] <= '0;
                    b_sr_q[j] <= '0;
                    v_sr_q[j] <= 1'b0;
                end
            end else begin
                a_sr_q[0] <= accept ? a_vec[i*W +: W] : '0;
                b_sr_q[0] <= accept ? b_vec[i*W +: W] : '0;
                v_sr_q[0] <= accept;
                for (int j = 1; j <= i; j++) begin
                    a_sr_q[j] <= a_sr_q[j-1];
                    b_sr_q[j] <= b_sr_q[j-1];
                    v_sr_q[j] <= v_sr_q[j-1];
                end
            end
        end

        assign a_edge[i*W +: W] = a_sr_q[i];
        assign b_edge[i*W +: W] = b_sr_q[i];
        assign lane_valid[i]    = v_sr_q[i];
    end

endmodule

// File: tb/tb_sysarray_skew_feeder.sv
module tb_sysarray_skew_feeder;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int LW = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   len;
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  a_vec;
    logic [N*W-1:0]  b_vec;
    logic [N*W-1:0]  a_edge;
    logic [N*W-1:0]  b_edge;
    logic [N-1:0]    lane_valid;
    logic            clear_acc;
    logic            busy;
    logic            done;

    sysarray_skew_feeder #(.N(N), .W(W), .LW(LW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_vec      (a_vec),
        .b_vec      (b_vec),
        .a_edge     (a_edge),
        .b_edge     (b_edge),
        .lane_valid (lane_valid),
        .clear_acc  (clear_acc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;

    // Values sampled on the falling edge of the current cycle.
    int             s_cyc, s_rdy, s_clr, s_busy, s_done, s_lv, s_acc;
    logic [N*W-1:0] s_a, s_b;

    typedef struct {
        int st, ln, vl, bt;
        int rdy, clr, bsy, dn;
        int l0, l1, l2, l3;
    } row_t;
    row_t rows[$];

    // Beat k: lane i = 10k+i (+100 on the B side). k < 0 means an all-zero slot.
    function automatic logic [N*W-1:0] vec_of(int k, int off);
        logic [N*W-1:0] v;
        v = '0;
        if (k >= 0)
            for (int i = 0; i < N; i++) v[i*W +: W] = W'(10 * k + i + off);
        return v;
    endfunction

    function automatic logic [N*W-1:0] edge_of(int l0, int l1, int l2, int l3, int off);
        int ls[N];
        logic [N*W-1:0] v;
        ls[0] = l0; ls[1] = l1; ls[2] = l2; ls[3] = l3;
        v = '0;
        for (int i = 0; i < N; i++)
            if (ls[i] >= 0) v[i*W +: W] = W'(10 * ls[i] + i + off);
        return v;
    endfunction

    function automatic int lv_of(int l0, int l1, int l2, int l3);
        return ((l0 >= 0) ? 1 : 0) | ((l1 >= 0) ? 2 : 0) | ((l2 >= 0) ? 4 : 0) | ((l3 >= 0) ? 8 : 0);
    endfunction

    function automatic void add(int st, int ln, int vl, int bt, int rdy, int clr, int bsy, int dn,
                                int l0, int l1, int l2, int l3);
        row_t r;
        r.st = st; r.ln = ln; r.vl = vl; r.bt = bt;
        r.rdy = rdy; r.clr = clr; r.bsy = bsy; r.dn = dn;
        r.l0 = l0; r.l1 = l1; r.l2 = l2; r.l3 = l3;
        rows.push_back(r);
    endfunction

    function automatic void add_drain(int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 1, 0, -1, -1, -1, -1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, s_cyc, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, s_cyc, act, exp);
        end
    endtask

    task automatic drive(input int st, input int ln, input int vl, input int bt);
        start    = 1'(st);
        len      = LW'(ln);
        in_valid = 1'(vl);
        a_vec    = vec_of(bt, 0);
        b_vec    = vec_of(bt, 100);
    endtask

    task automatic step();
        @(negedge clock);
        s_cyc  = cyc;
        s_rdy  = int'(in_ready);
        s_clr  = int'(clear_acc);
        s_busy = int'(busy);
        s_done = int'(done);
        s_lv   = int'(lane_valid);
        s_acc  = int'(in_ready && in_valid);
        s_a    = a_edge;
        s_b    = b_edge;
        acc_cnt += s_acc;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, s_rdy, 0);
        chk({nm, "_clear"}, s_clr, 0);
        chk({nm, "_busy"}, s_busy, 0);
        chk({nm, "_done"}, s_done, 0);
        chk({nm, "_lv"}, s_lv, 0);
        chkv({nm, "_a_edge"}, s_a, '0);
        chkv({nm, "_b_edge"}, s_b, '0);
    endtask

    // Runs one job with continuously valid beats; beat k = vec_of(k).
    // Returns right after the cycle in which done was seen, so the caller can
    // start another job in the very next cycle.
    task automatic run_job(input int ln, output int acc, output int tstart, output int tlast,
                           output int tdone, output int ndone, output int tclr,
                           output int rdy_after, output logic [N*W-1:0] a_at_l3);
        int k;
        int budget;
        k = 0; acc = 0; tlast = -1; tdone = -1; ndone = 0; tclr = -1; rdy_after = -1;
        a_at_l3 = '0;
        budget = 3 * ln + 60;
        drive(1, ln, 0, 0);
        step();
        tstart = s_cyc;
        chk("job_idle_at_start", s_busy, 0);
        chk("job_lanes_empty_at_start", s_lv, 0);
        for (int c = 0; c < budget; c++) begin
            drive(0, 0, 1, k);
            step();
            if (s_acc != 0) begin
                acc++;
                tlast = s_cyc;
                k++;
            end
            if (s_clr != 0 && tclr < 0) begin
                tclr = s_cyc;
                chk("job_lanes_empty_at_clear", s_lv, 0);
                chkv("job_a_empty_at_clear", s_a, '0);
            end
            if (tlast >= 0 && s_cyc == tlast + 1) rdy_after = s_rdy;
            if (tlast >= 0 && s_cyc == tlast + 4) a_at_l3 = s_a;
            if (s_done != 0) begin
                ndone++;
                tdone = s_cyc;
                break;
            end
        end
        if (tdone < 0) begin
            bad++;
            total++;
            $display("FAIL job_done_timeout cyc=%0d got=none want=done", cyc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        int ndone_seen;
        int acc, tstart, tlast, tdone, ndone, tclr, rdy_after;
        int acc2, tstart2, tlast2, tdone2, ndone2, tclr2, rdy_after2;
        logic [N*W-1:0] a_l3, a_l3b;

        // ---- power-up reset ----
        reset = 1'b1;
        drive(0, 0, 0, 0);
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();
        chk_all_zero("post_reset_idle");

        // ---- table: basic job len=3 (with an ignored start in FEED), then bubble job ----
        add(1, 3, 0, 0,  0, 0, 0, 0,  -1, -1, -1, -1);
        add(0, 0, 1, 0,  0, 1, 1, 0,  -1, -1, -1, -1);
        add(0, 0, 1, 0,  1, 0, 1, 0,  -1, -1, -1, -1);
        add(1, 9, 1, 1,  1, 0, 1, 0,   0, -1, -1, -1);
        add(0, 0, 1, 2,  1, 0, 1, 0,   1,  0, -1, -1);
        add(0, 0, 1, 3,  0, 0, 1, 0,   2,  1,  0, -1);
        add(0, 0, 1, 3,  0, 0, 1, 0,  -1,  2,  1,  0);
        add(0, 0, 0, 0,  0, 0, 1, 0,  -1, -1,  2,  1);
        add(0, 0, 0, 0,  0, 0, 1, 0,  -1, -1, -1,  2);
        add_drain(7);
        add(0, 0, 0, 0,  0, 0, 1, 1,  -1, -1, -1, -1);
        add(0, 0, 0, 0,  0, 0, 0, 0,  -1, -1, -1, -1);

        add(1, 3, 0, 0,  0, 0, 0, 0,  -1, -1, -1, -1);
        add(0, 0, 1, 0,  0, 1, 1, 0,  -1, -1, -1, -1);
        add(0, 0, 1, 0,  1, 0, 1, 0,  -1, -1, -1, -1);
        add(0, 0, 0, 7,  1, 0, 1, 0,   0, -1, -1, -1);
        add(0, 0, 1, 1,  1, 0, 1, 0,  -1,  0, -1, -1);
        add(0, 0, 1, 2,  1, 0, 1, 0,   1, -1,  0, -1);
        add(0, 0, 0, 0,  0, 0, 1, 0,   2,  1, -1,  0);
        add(0, 0, 0, 0,  0, 0, 1, 0,  -1,  2,  1, -1);
        add(0, 0, 0, 0,  0, 0, 1, 0,  -1, -1,  2,  1);
        add(0, 0, 0, 0,  0, 0, 1, 0,  -1, -1, -1,  2);
        add_drain(7);
        add(0, 0, 0, 0,  0, 0, 1, 1,  -1, -1, -1, -1);
        add(0, 0, 0, 0,  0, 0, 0, 0,  -1, -1, -1, -1);

        acc0 = acc_cnt;
        foreach (rows[i]) begin
            drive(rows[i].st, rows[i].ln, rows[i].vl, rows[i].bt);
            step();
            chk($sformatf("row%0d_ready", i), s_rdy, rows[i].rdy);
            chk($sformatf("row%0d_clear", i), s_clr, rows[i].clr);
            chk($sformatf("row%0d_busy", i), s_busy, rows[i].bsy);
            chk($sformatf("row%0d_done", i), s_done, rows[i].dn);
            chk($sformatf("row%0d_lv", i), s_lv, lv_of(rows[i].l0, rows[i].l1, rows[i].l2, rows[i].l3));
            chkv($sformatf("row%0d_a_edge", i), s_a, edge_of(rows[i].l0, rows[i].l1, rows[i].l2, rows[i].l3, 0));
            chkv($sformatf("row%0d_b_edge", i), s_b, edge_of(rows[i].l0, rows[i].l1, rows[i].l2, rows[i].l3, 100));
        end
        chk("table_accepts", acc_cnt - acc0, 6);

        // ---- start with len=0 is ignored ----
        drive(1, 0, 1, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        chk("len0_busy", s_busy, 0);
        chk("len0_clear", s_clr, 0);
        step();
        chk("len0_busy_later", s_busy, 0);

        // ---- reset mid-job aborts it without done ----
        drive(1, 5, 0, 0);
        step();
        drive(0, 0, 1, 0);
        step();
        step();
        drive(0, 0, 1, 1);
        step();
        reset = 1'b1;
        drive(0, 0, 1, 2);
        step();
        step();
        chk_all_zero("midreset");
        reset = 1'b0;
        drive(0, 0, 1, 3);
        step();
        chk_all_zero("after_midreset");
        ndone_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            ndone_seen += s_done;
        end
        chk("aborted_job_no_done", ndone_seen, 0);

        // ---- maximum length job ----
        run_job(255, acc, tstart, tlast, tdone, ndone, tclr, rdy_after, a_l3);
        chk("max_accepts", acc, 255);
        chk("max_ndone", ndone, 1);
        chk("max_done_latency", tdone - tlast, 12);
        chk("max_clear_after_start", tclr - tstart, 1);
        chk("max_ready_drops", rdy_after, 0);
        chkv("max_last_beat_lane3", a_l3, edge_of(-1, -1, -1, 254, 0));

        // ---- back-to-back jobs: second start right after first done ----
        run_job(2, acc, tstart, tlast, tdone, ndone, tclr, rdy_after, a_l3);
        chk("b2b1_accepts", acc, 2);
        chk("b2b1_done_latency", tdone - tlast, 12);
        run_job(3, acc2, tstart2, tlast2, tdone2, ndone2, tclr2, rdy_after2, a_l3b);
        chk("b2b2_start_cycle", tstart2 - tdone, 1);
        chk("b2b2_clear_cycle", tclr2 - tdone, 2);
        chk("b2b2_accepts", acc2, 3);
        chk("b2b2_done_latency", tdone2 - tlast2, 12);
        chkv("b2b2_last_beat_lane3", a_l3b, edge_of(-1, -1, -1, 2, 0));
        drive(0, 0, 0, 0);
        step();
        chk("b2b2_busy_after_done", s_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
